fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch front end of the RISC-V datapath. Owns the program counter and issues in-order word requests to instruction memory over a valid/ready channel. Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake. Handles redirects from branch/jump resolution by flushing buffered and in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- FIFO_DEPTH, 4, instruction buffer entries; power of two, ≥2; also the in-flight request limit

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word address of request (bits [1:0] always 0)
- imem_rsp_valid  in  1  response valid; in order, one per accepted request, ≥1 cycle after acceptance, no backpressure
- imem_rsp_data  in  32  returned instruction
- redirect_valid  in  1  redirect PC (taken branch, JAL, JALR, trap)
- redirect_pc  in  32  new PC
- dec_valid  out  1  instruction available to decode
- dec_ready  in  1  decode accepts
- dec_instr  out  32  instruction
- dec_pc  out  32  PC of dec_instr
- dec_fault  out  1  instruction-address-misaligned fault marker

## Operation
- State: pc (next request address), rsp_pc (PC of next kept response), outstanding counter, drop counter, FIFO of {instr, pc, fault}, halted flag.
- Request issue: imem_req_valid = !halted && (outstanding + fifo_count < FIFO_DEPTH); imem_req_addr = pc. Accept (valid&&ready): pc += 4 (wraps mod 2^32), outstanding += 1. Once asserted, valid and addr held stable until accepted, except when withdrawn in a redirect cycle.
- Response: outstanding −= 1. If drop > 0: discard, drop −= 1. Else push {imem_rsp_data, rsp_pc, 0}, rsp_pc += 4. Credit rule guarantees push never overflows.
- Decode: dec_valid = FIFO non-empty; outputs show head entry; pop on dec_valid && dec_ready.
- Redirect (highest priority): next cycle FIFO empty, pc = rsp_pc = redirect_pc, drop = outstanding + req_fire − rsp_fire (evaluated this cycle), halted = 0; a response arriving this cycle is discarded. A decode handshake in the redirect cycle completes normally; downstream owns squashing it.
- Misaligned redirect (redirect_pc[1:0] ≠ 0): set halted = 1, issue no requests. Once drop = 0, push one entry {32'h0000_0013, redirect_pc, 1}. Fetch stays halted after it is popped, until next redirect.
- Simultaneous push and pop: both occur; count unchanged.

## Timing
- Reset values: imem_req_valid 0 while rst high; pc = rsp_pc = RESET_PC; outstanding = drop = 0; FIFO empty; halted 0; dec_valid 0, dec_instr 0, dec_pc 0, dec_fault 0.
- First cycle after rst deasserts: imem_req_valid = 1, addr = RESET_PC.
- Response in cycle t → dec_valid in t+1 (registered FIFO; no combinational path from imem_rsp_* or dec_ready to any output).
- Redirect in cycle t → dec_valid = 0 and imem_req_valid = 1 with addr = redirect_pc in t+1 (if aligned and credits allow).
- 1-cycle memory, dec_ready held high, FIFO_DEPTH 4: one instruction per cycle sustained.
- Reset mid-operation: all state cleared immediately; stale responses arriving after reset release are ignored only if the memory is also reset. The memory is reset together with this block.

## Test plan
- Reset release, 1-cycle memory, dec_ready=1: addrs 0,4,8,…; dec_pc 0,4,8 on consecutive cycles from cycle 2; dec_instr matches memory.
- dec_ready=0 for 10 cycles: exactly 4 requests issued, then imem_req_valid=0; release → 4 buffered entries drain in order, then fetching resumes with no gap or duplicate.
- 3-cycle memory latency, redirect to 0x100 with 3 requests outstanding: all 3 responses discarded; first dec_pc = 0x100 with correct data.
- Redirect in same cycle as a response and a request acceptance: both late items dropped (drop=outstanding+1−1); no stale PC reaches decode.
- Redirect to 0x102: no requests issued; single entry dec_fault=1, dec_pc=0x102, dec_instr=0x00000013; later redirect to 0x200 resumes normal fetch.
- imem_req_ready toggled randomly while the PC runs past 0xFFFF_FFFC: address held stable until accepted; PC wraps to 0x0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end.
// Owns the PC, issues in-order word requests to instruction memory under a
// credit limit, buffers returned instructions with their PCs and hands them
// to decode. Redirects flush the buffer and squash in-flight responses.
`timescale 1ns/1ps

module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,

    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,

    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        dec_fault
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } entry_t;

    // Architectural state
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [31:0]      fault_pc_q, fault_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             halted_q, halted_d;
    logic             fault_pend_q, fault_pend_d;
    entry_t           fifo_q [FIFO_DEPTH];

    // Combinational helpers
    logic [CNT_W:0]   inflight_c;
    logic             credit_c;
    logic             req_fire_c;
    logic             rsp_fire_c;
    logic             pop_c;
    logic             push_c;
    logic             misaligned_c;
    entry_t           push_entry_c;
    entry_t           head_c;

    // Credit check: requests in flight plus buffered entries never exceed the buffer
    always_comb begin
        inflight_c = {1'b0, outst_q} + {1'b0, count_q};
        credit_c   = (inflight_c < DEPTH_EXT);
    end

    // Request channel and handshake qualifiers; all driven from registered state
    always_comb begin
        imem_req_valid = !rst && !halted_q && credit_c;
        imem_req_addr  = pc_q;
        req_fire_c     = imem_req_valid && imem_req_ready;
        rsp_fire_c     = imem_rsp_valid;
        misaligned_c   = (redirect_pc[1:0] != 2'b00);
    end

    // Decode side shows the FIFO head
    always_comb begin
        head_c    = fifo_q[rd_ptr_q];
        dec_valid = (count_q != '0);
        dec_instr = head_c.instr;
        dec_pc    = head_c.pc;
        dec_fault = head_c.fault;
        pop_c     = dec_valid && dec_ready;
    end

    // Next-state: PC advance, response accounting, redirect flush, fault injection
    always_comb begin
        pc_d         = pc_q;
        rsp_pc_d     = rsp_pc_q;
        fault_pc_d   = fault_pc_q;
        drop_d       = drop_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        halted_d     = halted_q;
        fault_pend_d = fault_pend_q;
        push_c       = 1'b0;
        push_entry_c = '0;

        outst_d = outst_q + CNT_W'(req_fire_c) - CNT_W'(rsp_fire_c);

        if (req_fire_c) begin
            pc_d = pc_q + 32'd4;
        end

        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path
            pc_d         = redirect_pc;
            rsp_pc_d     = redirect_pc;
            fault_pc_d   = redirect_pc;
            drop_d       = outst_d;
            halted_d     = misaligned_c;
            fault_pend_d = misaligned_c;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
        end else begin
            if (rsp_fire_c) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CNT_W'(1);
                end else begin
                    push_c       = 1'b1;
                    push_entry_c = '{instr: imem_rsp_data, pc: rsp_pc_q, fault: 1'b0};
                    rsp_pc_d     = rsp_pc_q + 32'd4;
                end
            end else if (fault_pend_q && (drop_q == '0)) begin
                // Fault marker waits until stale responses have drained
                push_c       = 1'b1;
                push_entry_c = '{instr: NOP_INSTR, pc: fault_pc_q, fault: 1'b1};
                fault_pend_d = 1'b0;
            end

            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // Control and pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            rsp_pc_q     <= RESET_PC;
            fault_pc_q   <= '0;
            outst_q      <= '0;
            drop_q       <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            halted_q     <= 1'b0;
            fault_pend_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            rsp_pc_q     <= rsp_pc_d;
            fault_pc_q   <= fault_pc_d;
            outst_q      <= outst_d;
            drop_q       <= drop_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            halted_q     <= halted_d;
            fault_pend_q <= fault_pend_d;
        end
    end

    // Instruction buffer storage; cleared on reset so decode outputs read zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push_c) begin
            fifo_q[wr_ptr_q] <= push_entry_c;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a latency-configurable
// in-order memory model and a decode-side monitor.
`timescale 1ns/1ps

module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_fault;

    fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_fault      (dec_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    int          total = 0;
    int          bad = 0;
    int          lat = 1;
    bit          rnd = 1'b0;
    int          req_cnt = 0;
    int          hs_first = -1;
    int          hs_last = 0;
    int          rel = 0;
    int          snap = 0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic        pred = 1'b0;
    logic [31:0] pa = 32'h0;

    // Memory contents: a distinct word per address
    function automatic logic [31:0] word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic fault);
        exp_t e;
        e.pc    = pc;
        e.instr = fault ? 32'h0000_0013 : word(pc);
        e.fault = fault;
        exp_q.push_back(e);
    endtask

    task automatic push_run(input logic [31:0] start, input int n);
        logic [31:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            push_exp(a, 1'b0);
            a = a + 32'd4;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input int max_cyc, input string name);
        for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d entries left want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        req_cnt = 0;
        step();
        step();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_instr", dec_instr, 32'd0);
        chk("rst_dec_pc", dec_pc, 32'd0);
        chk("rst_dec_fault", 32'(dec_fault), 32'd0);
        rst = 1'b0;
        rel = cyc;
        #1;
        chk("rel_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rel_req_addr", imem_req_addr, RESET_PC);
    endtask

    task automatic redirect_to(input logic [31:0] pc, input int n, input bit chk_req);
        dec_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = pc;
        if (pc[1:0] != 2'b00) push_exp(pc, 1'b1);
        else push_run(pc, n);
        step();
        redirect_valid = 1'b0;
        chk("redir_dec_valid", 32'(dec_valid), 32'd0);
        if (chk_req) begin
            chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
            chk("redir_req_addr", imem_req_addr, pc);
        end
        dec_ready = 1'b1;
    endtask

    // In-order memory: fixed latency, optional random ready, reset with the DUT
    task automatic mem_proc();
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                pend_q.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
                imem_req_ready = 1'b0;
                pv = 1'b0;
            end else begin
                if (pv && !pr && !pred) begin
                    chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
                    chk("req_hold_addr", imem_req_addr, pa);
                end
                if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = word(pend_q[0].addr);
                    void'(pend_q.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data  = 32'h0;
                end
                imem_req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (imem_req_valid && imem_req_ready) begin
                    pend_q.push_back('{imem_req_addr, cyc + lat});
                    req_cnt++;
                end
                pv   = imem_req_valid;
                pr   = imem_req_ready;
                pa   = imem_req_addr;
                pred = redirect_valid;
            end
        end
    endtask

    // Decode monitor: every handshake is checked against the scoreboard head
    task automatic mon_proc();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && dec_valid && dec_ready) begin
                if (hs_first < 0) hs_first = cyc;
                hs_last = cyc;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL dec_unexpected: got pc=%h instr=%h want no handshake", dec_pc, dec_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("dec_pc", dec_pc, e.pc);
                    chk("dec_instr", dec_instr, e.instr);
                    chk("dec_fault", 32'(dec_fault), 32'(e.fault));
                end
            end
        end
    endtask

    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b0;
        fork
            mem_proc();
            mon_proc();
        join_none

        // Streaming from reset with 1-cycle memory
        dec_ready = 1'b1;
        lat = 1;
        hs_first = -1;
        do_reset();
        push_run(RESET_PC, 16);
        wait_empty(100, "stream");
        chk("stream_first_cycle", 32'(hs_first), 32'(rel + 2));
        chk("stream_back_to_back", 32'(hs_last - hs_first), 32'd15);

        // Redirect mid-stream: response and request acceptance in the same cycle
        redirect_to(32'h0000_0300, 8, 1'b1);
        wait_empty(100, "redir300");
        dec_ready = 1'b0;

        // Decode stall: credits cap requests at the buffer depth
        lat = 1;
        do_reset();
        repeat (10) step();
        chk("stall_req_count", 32'(req_cnt), 32'd4);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_dec_valid", 32'(dec_valid), 32'd1);
        push_run(RESET_PC, 12);
        dec_ready = 1'b1;
        wait_empty(100, "stall");
        dec_ready = 1'b0;

        // 3-cycle memory: redirect with three requests outstanding
        lat = 3;
        do_reset();
        step();
        step();
        step();
        chk("lat3_dec_valid", 32'(dec_valid), 32'd0);
        redirect_to(32'h0000_0100, 8, 1'b1);
        wait_empty(200, "redir100");

        // Misaligned redirect: single fault entry, fetch halted
        redirect_to(32'h0000_0102, 0, 1'b0);
        chk("mis_req_valid", 32'(imem_req_valid), 32'd0);
        snap = req_cnt;
        wait_empty(50, "misaligned");
        repeat (5) step();
        chk("mis_no_requests", 32'(req_cnt), 32'(snap));
        chk("mis_halt_valid", 32'(imem_req_valid), 32'd0);
        chk("mis_halt_dec", 32'(dec_valid), 32'd0);
        redirect_to(32'h0000_0200, 8, 1'b1);
        wait_empty(200, "redir200");

        // PC wrap with random request backpressure
        rnd = 1'b1;
        lat = 2;
        redirect_to(32'hFFFF_FFF0, 10, 1'b0);
        wait_empty(400, "wrap");
        rnd = 1'b0;
        dec_ready = 1'b0;

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
